// File: rtl/prog_timer.sv
// Programmable timebase: prescaled counter with latched period, one-shot or
// periodic modes, a terminal-count tick, a done flag and a compare-based PWM.
module prog_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  oneshot_i,
  input  logic [WIDTH-1:0]      period_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [WIDTH-1:0]      compare_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  tick_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pwm_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  state_t                  state_q;
  logic [WIDTH-1:0]        count_q;
  logic [WIDTH-1:0]        period_q;
  logic [PRESCALE_W-1:0]   psc_q;
  logic [PRESCALE_W-1:0]   prescale_q;
  logic                    mode_q;
  logic                    tick_q;
  logic                    step_d;
  logic                    terminal_d;

  always_comb begin
    step_d     = (state_q == S_RUN) && enable_i && (psc_q == prescale_q);
    terminal_d = (count_q == period_q);
  end

  // Priority per edge: reset, then stop, then start, then counting.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      period_q   <= '0;
      psc_q      <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (stop_i) begin
        state_q <= S_IDLE;
      end else if (start_i) begin
        period_q   <= period_i;
        prescale_q <= prescale_i;
        mode_q     <= oneshot_i;
        count_q    <= '0;
        psc_q      <= '0;
        state_q    <= S_RUN;
      end else if (state_q == S_RUN && enable_i) begin
        if (step_d) begin
          psc_q <= '0;
          if (terminal_d) begin
            tick_q <= 1'b1;
            if (mode_q) begin
              state_q <= S_DONE;
            end else begin
              count_q <= '0;
            end
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end else begin
          psc_q <= psc_q + PSC_ONE;
        end
      end
    end
  end

  always_comb begin
    count_o = count_q;
    tick_o  = tick_q;
    busy_o  = (state_q == S_RUN);
    done_o  = (state_q == S_DONE);
    pwm_o   = (state_q == S_RUN) && (count_q < compare_i);
  end

endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer: directed scenarios plus random traffic, each cycle
// checked against a model built on enabled-cycle arithmetic.
module tb_prog_timer;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, en, start, stop, os;
  logic [W-1:0]  per, cmp;
  logic [PW-1:0] psc;
  logic [W-1:0]  dut_count;
  logic          dut_tick, dut_busy, dut_done, dut_pwm;

  int tests = 0;
  int fails = 0;

  // Model state: 0 idle, 1 run, 2 done.
  int m_state = 0, m_count = 0, m_tick = 0, m_ecnt = 0;
  int m_P = 0, m_S = 0, m_mode = 0;

  prog_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .enable_i   (en),
    .start_i    (start),
    .stop_i     (stop),
    .oneshot_i  (os),
    .period_i   (per),
    .prescale_i (psc),
    .compare_i  (cmp),
    .count_o    (dut_count),
    .tick_o     (dut_tick),
    .busy_o     (dut_busy),
    .done_o     (dut_done),
    .pwm_o      (dut_pwm)
  );

  always #5 clk = ~clk;

  // Counter value derived from the number of enabled RUN cycles since start.
  task automatic model_edge();
    int steps;
    if (rst) begin
      m_state = 0; m_count = 0; m_tick = 0; m_ecnt = 0;
      m_P = 0; m_S = 0; m_mode = 0;
    end else if (stop) begin
      m_state = 0; m_tick = 0;
    end else if (start) begin
      m_P = int'(per); m_S = int'(psc); m_mode = int'(os);
      m_ecnt = 0; m_count = 0; m_tick = 0; m_state = 1;
    end else begin
      m_tick = 0;
      if (m_state == 1 && en) begin
        m_ecnt++;
        if (m_ecnt % (m_S + 1) == 0) begin
          steps = m_ecnt / (m_S + 1);
          if (m_mode != 0) begin
            if (steps == m_P + 1) begin
              m_state = 2; m_count = m_P; m_tick = 1;
            end else begin
              m_count = steps;
            end
          end else begin
            m_count = steps % (m_P + 1);
            m_tick  = (m_count == 0) ? 1 : 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [W-1:0] e_count;
    logic         e_tick, e_busy, e_done, e_pwm;
    e_count = W'(m_count);
    e_tick  = (m_tick != 0);
    e_busy  = (m_state == 1);
    e_done  = (m_state == 2);
    e_pwm   = (m_state == 1) && (m_count < int'(cmp));
    tests++;
    assert (dut_count === e_count) else begin
      fails++; $error("FAIL %s count: got %0d expected %0d", tag, dut_count, e_count);
    end
    tests++;
    assert (dut_tick === e_tick) else begin
      fails++; $error("FAIL %s tick: got %b expected %b", tag, dut_tick, e_tick);
    end
    tests++;
    assert (dut_busy === e_busy) else begin
      fails++; $error("FAIL %s busy: got %b expected %b", tag, dut_busy, e_busy);
    end
    tests++;
    assert (dut_done === e_done) else begin
      fails++; $error("FAIL %s done: got %b expected %b", tag, dut_done, e_done);
    end
    tests++;
    assert (dut_pwm === e_pwm) else begin
      fails++; $error("FAIL %s pwm: got %b expected %b", tag, dut_pwm, e_pwm);
    end
  endtask

  // Advance n edges; strobes are one-cycle so they are cleared after each edge.
  task automatic cyc(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check(tag);
      start = 1'b0; stop = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic go(input logic [W-1:0] p, input logic [PW-1:0] s, input logic o);
    per = p; psc = s; os = o; start = 1'b1;
  endtask

  int tick_seen;

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; os = 1'b0;
    per = '0; psc = '0; cmp = '0;
    cyc(2, "reset");

    // Periodic, period 3, prescale 0: ticks every 4 cycles.
    en = 1'b1; cmp = 8'd2;
    go(8'd3, 4'd0, 1'b0);
    cyc(14, "periodic");
    tick_seen = 0;
    repeat (8) begin
      cyc(1, "periodic_cnt");
      if (dut_tick) tick_seen++;
    end
    tests++;
    assert (tick_seen == 2) else begin
      fails++; $error("FAIL tick_interval: got %0d ticks expected %0d", tick_seen, 2);
    end

    // Reset held two cycles mid-run.
    rst = 1'b1; cyc(1, "reset_mid");
    rst = 1'b1; cyc(1, "reset_mid");
    cyc(2, "after_reset");

    // Prescale 2, period 1, with an enable gap of 4 cycles.
    go(8'd1, 4'd2, 1'b0);
    cyc(10, "prescale");
    en = 1'b0; cyc(4, "enable_low");
    en = 1'b1; cyc(12, "prescale_resume");

    // One-shot, period 5: done in cycle 7 then holds.
    go(8'd5, 4'd0, 1'b1);
    cyc(7, "oneshot");
    tests++;
    assert (dut_done === 1'b1 && dut_tick === 1'b1 && dut_count === 8'd5) else begin
      fails++; $error("FAIL oneshot_done: got done=%b tick=%b count=%0d expected 1 1 5",
                      dut_done, dut_tick, dut_count);
    end
    cyc(20, "oneshot_hold");
    go(8'd5, 4'd0, 1'b1);
    cyc(3, "oneshot_restart");

    // stop+start together: stop wins, count held.
    go(8'd7, 4'd0, 1'b0);
    cyc(4, "run7");
    go(8'd2, 4'd0, 1'b0); stop = 1'b1;
    cyc(3, "stop_start");
    // Restart at count 2, then change period mid-run.
    go(8'd5, 4'd0, 1'b0);
    cyc(3, "run5");
    go(8'd5, 4'd0, 1'b0);
    cyc(2, "restart");
    per = 8'd1; psc = 4'd3; os = 1'b1;
    cyc(14, "period_change");

    // PWM compare sweep, period 3.
    foreach (cmp[i]) begin end
    go(8'd3, 4'd0, 1'b0); cmp = 8'd2;
    cyc(8, "pwm2");
    cmp = 8'd0;   cyc(6, "pwm0");
    cmp = 8'd200; cyc(6, "pwm200");
    stop = 1'b1;  cyc(3, "pwm_idle");

    // Full-range period wraps to 0.
    go(8'd255, 4'd0, 1'b0); cmp = 8'd128;
    cyc(262, "wrap");

    // Random traffic, including mid-run changes of period/prescale/compare.
    for (int k = 0; k < 1500; k++) begin
      en    = ($urandom_range(0, 9) < 8);
      per   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      psc   = 4'($urandom_range(0, 3));
      os    = 1'($urandom_range(0, 1));
      cmp   = 8'($urandom_range(0, 8));
      start = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc(1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_timer.md
# prog_timer

Parametrised, programmable successor to the team's free-running pulse counter. It adds a prescaler, a latched period and one-shot/periodic modes. It also provides a terminal-count tick, a done flag and a compare-based PWM output. It sits beside the control FSMs as the common timebase for delays, refresh ticks and duty-cycle generation.

## Interface
- WIDTH, 8, width of main counter, period and compare
- PRESCALE_W, 4, width of prescaler counter and prescale input

- clock  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  count qualifier; low freezes prescaler and counter
- start  in  1  one-cycle strobe: latch period/prescale/mode, clear counters, enter RUN
- stop  in  1  one-cycle strobe: return to IDLE, counter holds value
- oneshot  in  1  mode latched at start: 1 = stop after first terminal count, 0 = periodic
- period  in  WIDTH  terminal count; counter runs 0..period (period+1 steps)
- prescale  in  PRESCALE_W  counter steps once per prescale+1 enabled cycles
- compare  in  WIDTH  PWM threshold, used live (not latched)
- count  out  WIDTH  current counter value
- tick  out  1  one-cycle pulse on each terminal step
- busy  out  1  high in RUN
- done  out  1  high in DONE (one-shot completed)
- pwm  out  1  busy && (count < compare), combinational from registers

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- Priority per edge: reset > stop > start > counting.
- start (any state): period_q<=period, prescale_q<=prescale, mode_q<=oneshot, count<=0, psc<=0, done<=0, state<=RUN. start while RUN restarts.
- stop (any state): state<=IDLE, done<=0, count and psc hold. stop and start asserted together: stop wins.
- RUN, enable=0: psc, count and state hold; no tick.
- RUN, enable=1: if psc==prescale_q, a step occurs and psc<=0; else psc<=psc+1.
- Step, count!=period_q: count<=count+1.
- Step, count==period_q, periodic: count<=0, tick<=1.
- Step, count==period_q, one-shot: count holds at period_q, tick<=1, state<=DONE, done<=1.
- DONE: everything holds until start, stop or reset.
- period_q=0: every step is terminal. prescale_q=0: one step per enabled cycle.
- All comparisons are unsigned. Count never exceeds period_q. period = 2^WIDTH-1 wraps to 0 naturally.
- Changing period or prescale mid-run has no effect until the next start. Changing compare acts immediately on pwm.

## Timing
- Reset values: count=0, tick=0, busy=0, done=0, pwm=0. Internal: psc=0, period_q=0, prescale_q=0, mode_q=0.
- start sampled at edge N: busy=1 and count=0 from cycle N+1. The first step edge is at N+1+prescale_q, with enable held high.
- tick is registered on the terminal-step edge. It is high for exactly the following cycle (periodic: the cycle count reads 0).
- Periodic tick interval with enable held high: (period_q+1)*(prescale_q+1) cycles.
- One-shot: done and tick rise in the same cycle, and busy falls in that cycle.
- Reset mid-operation: all outputs are at reset values in the cycle after the reset edge.

## Test plan
- Reset: drive reset 2 cycles mid-RUN -> count=0, tick=0, busy=0, done=0, pwm=0 next cycle.
- Periodic, prescale=0, period=3, enable=1, start at cycle 0:
  - count reads 0,1,2,3,0,1… from cycle 1.
  - tick high in cycles 5, 9, 13.
- Prescale=2, period=1: count changes every 3 cycles and tick fires every 6 cycles. Deasserting enable for 4 cycles delays the next tick by exactly 4.
- One-shot, period=5, prescale=0:
  - done=1 and tick=1 in cycle 7, busy=0.
  - count holds 5 and no further ticks for 20 cycles.
  - A new start clears done.
- Control priority: stop+start in the same cycle -> IDLE, count held. start during RUN at count=2 -> count=0 next cycle. Changing period mid-run does not alter the current tick interval.
- PWM, period=3, prescale=0:
  - compare=2: pwm high for 2 of every 4 cycles.
  - compare=0: pwm stays low.
  - compare=200: pwm high whenever busy.
  - pwm=0 in IDLE.
